// File: rtl/spikey_spi_ctrl_if.sv
// Front-end request/response bundle for the spikey SPI transaction sequencer.
// master = register/TileLink front end, slave = spikey_spi_ctrl.
interface spikey_spi_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [1:0]        div_sel;
  logic              abort;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;

  modport master (
    output tx_valid, tx_data, div_sel, abort,
    input  tx_ready, rx_valid, rx_data, busy
  );

  modport slave (
    input  tx_valid, tx_data, div_sel, abort,
    output tx_ready, rx_valid, rx_data, busy
  );
endinterface

// File: rtl/spikey_spi_ctrl.sv
// SPI mode-0 transaction sequencer: one word per accept, MSB first, realigns the divider at start.
// Fixed accept-to-rx_valid latency per div_sel; tx_ready only in IDLE, requests elsewhere are dropped.
module spikey_spi_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CS_HOLD = 2,
  parameter int CS_GAP  = 4
) (
  input  logic                 FCLK,
  input  logic                 RST_N,
  spikey_spi_ctrl_if.slave     host,
  output logic                 div_rst,
  input  logic [3:0]           fclk_div,
  input  logic [3:0]           fclk_div_pp,
  input  logic [3:0]           fclk_div_np,
  output logic                 spi_cs_n,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam int BC_W   = $clog2(DATA_W + 1);
  localparam int TM_MAX = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int TM_W   = (TM_MAX < 2) ? 1 : $clog2(TM_MAX);
  localparam logic [BC_W-1:0] BC_FULL   = BC_W'(DATA_W);
  localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(CS_HOLD - 1);
  localparam logic [TM_W-1:0] GAP_LAST  = TM_W'(CS_GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_SHIFT, S_HOLD, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        sel_q, sel_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TM_W-1:0]   tmr_q, tmr_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic tap, tap_pp, tap_np, accept;

  assign tap    = fclk_div[sel_q];
  assign tap_pp = fclk_div_pp[sel_q];
  assign tap_np = fclk_div_np[sel_q];
  assign accept = host.tx_valid && (state_q == S_IDLE);

  always_ff @(posedge FCLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (host.tx_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = host.abort ? S_GAP : S_SHIFT;
      S_SHIFT: begin
        if (host.abort)                            state_d = S_GAP;
        else if (tap_np && (bit_cnt_q == BC_FULL)) state_d = S_HOLD;
      end
      S_HOLD:  if (host.abort || (tmr_q == HOLD_LAST)) state_d = S_GAP;
      S_GAP:   if (tmr_q == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // SCLK follows the tap directly, so it is low on SHIFT entry (divider just reset) and exit (np).
  always_comb begin
    host.tx_ready = (state_q == S_IDLE);
    host.busy     = (state_q != S_IDLE);
    div_rst       = (state_q == S_ALIGN);
    spi_cs_n      = !((state_q == S_ALIGN) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    spi_sclk      = (state_q == S_SHIFT) && tap;
  end

  always_comb begin
    shift_d    = shift_q;
    sel_d      = sel_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tmr_d      = '0;
    if ((state_d == state_q) && ((state_q == S_HOLD) || (state_q == S_GAP)))
      tmr_d = tmr_q + TM_W'(1);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d   = host.tx_data;
          sel_d     = host.div_sel;
          bit_cnt_d = '0;
          mosi_d    = host.tx_data[DATA_W-1];
        end
      end
      S_ALIGN: bit_cnt_d = '0;
      S_SHIFT: begin
        if (tap_pp) begin
          shift_d   = {shift_q[DATA_W-2:0], spi_miso};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
        // Next bit goes out a half period before the following rise.
        if (tap_np && (bit_cnt_q < BC_FULL)) mosi_d = shift_q[DATA_W-1];
      end
      S_HOLD: begin
        if ((state_d == S_GAP) && !host.abort) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == S_GAP) mosi_d = 1'b0;
  end

  always_ff @(posedge FCLK) begin
    if (!RST_N) begin
      shift_q    <= '0;
      sel_q      <= '0;
      bit_cnt_q  <= '0;
      tmr_q      <= '0;
      mosi_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      sel_q      <= sel_d;
      bit_cnt_q  <= bit_cnt_d;
      tmr_q      <= tmr_d;
      mosi_q     <= mosi_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign spi_mosi      = mosi_q;
  assign host.rx_data  = rx_data_q;
  assign host.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spikey_spi_ctrl.sv
// Directed bench for spikey_spi_ctrl with a behavioural free-running divider and MISO loopback.
module tb_spikey_spi_ctrl;

  logic       FCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       div_rst;
  logic [3:0] fclk_div, fclk_div_pp, fclk_div_np;
  logic       spi_cs_n, spi_sclk, spi_mosi, spi_miso;
  logic       loop_en = 1'b1;
  logic       miso_fix = 1'b0;

  logic [3:0] dcnt_q = 4'd0;
  logic [3:0] dprev_q = 4'd0;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0, last_rise = 0, last_per = 0;
  int n_rise = 0, n_rvld = 0, n_divrst = 0, n_glitch = 0;
  int run_low = 0, run_high = 0, last_cs_low = 0, last_cs_high = 0;
  logic        sclk_p = 1'b0;
  logic [31:0] mosi_hist = '0;

  spikey_spi_ctrl_if #(.DATA_W(8)) bus ();

  spikey_spi_ctrl #(.DATA_W(8), .CS_HOLD(2), .CS_GAP(4)) dut (
    .FCLK        (FCLK),
    .RST_N       (RST_N),
    .host        (bus),
    .div_rst     (div_rst),
    .fclk_div    (fclk_div),
    .fclk_div_pp (fclk_div_pp),
    .fclk_div_np (fclk_div_np),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  always #5 FCLK = ~FCLK;

  // Divider: free-running counter, cleared by system reset or div_rst.
  always_ff @(posedge FCLK) begin
    if (!RST_N || div_rst) begin
      dcnt_q  <= 4'd0;
      dprev_q <= 4'd0;
    end else begin
      dprev_q <= dcnt_q;
      dcnt_q  <= dcnt_q + 4'd1;
    end
  end
  assign fclk_div    = dcnt_q;
  assign fclk_div_pp = dcnt_q & ~dprev_q;
  assign fclk_div_np = ~dcnt_q & dprev_q;
  assign spi_miso    = loop_en ? spi_mosi : miso_fix;

  always @(negedge FCLK) begin
    cyc <= cyc + 1;
    if (spi_sclk === 1'b1 && !sclk_p) begin
      n_rise    <= n_rise + 1;
      last_per  <= cyc - last_rise;
      last_rise <= cyc;
      mosi_hist <= {mosi_hist[30:0], spi_mosi};
    end
    sclk_p <= (spi_sclk === 1'b1);
    if (bus.rx_valid === 1'b1) n_rvld <= n_rvld + 1;
    if (div_rst === 1'b1) n_divrst <= n_divrst + 1;
    if (spi_sclk === 1'b1 && spi_cs_n === 1'b1) n_glitch <= n_glitch + 1;
    if (spi_cs_n === 1'b0) begin
      run_low <= run_low + 1;
      if (run_high != 0) begin
        last_cs_high <= run_high;
        run_high     <= 0;
      end
    end else begin
      run_high <= run_high + 1;
      if (run_low != 0) begin
        last_cs_low <= run_low;
        run_low     <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    int k;
    k = 0;
    @(negedge FCLK);
    while (!bus.tx_ready && k < 300) begin
      @(negedge FCLK);
      k++;
    end
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    bus.div_sel  = s;
    @(negedge FCLK);
    bus.tx_valid = 1'b0;
    bus.div_sel  = ~s;
  endtask

  task automatic wait_rx(input string tag, input int limit);
    int k;
    k = 0;
    do begin
      @(negedge FCLK);
      k++;
    end while (bus.rx_valid !== 1'b1 && k < limit);
    if (bus.rx_valid !== 1'b1) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"},     32'(spi_cs_n),     32'd1);
    chk({tag, "_sclk"},     32'(spi_sclk),     32'd0);
    chk({tag, "_mosi"},     32'(spi_mosi),     32'd0);
    chk({tag, "_tx_ready"}, 32'(bus.tx_ready), 32'd1);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    chk({tag, "_rx_data"},  32'(bus.rx_data),  32'd0);
    chk({tag, "_div_rst"},  32'(div_rst),      32'd0);
  endtask

  initial begin
    int r0, v0, d0, g0, k, rises, gcyc;
    logic sp;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    bus.div_sel  = 2'd0;
    bus.abort    = 1'b0;

    // Reset, then idle.
    RST_N = 1'b0;
    repeat (3) @(negedge FCLK);
    RST_N = 1'b1;
    @(negedge FCLK);
    chk_reset_outputs("reset");
    repeat (5) @(negedge FCLK);
    chk("idle_no_rx", 32'(n_rvld), 32'd0);

    // Loopback, sel=0, 0xA5.
    r0 = n_rise; v0 = n_rvld; d0 = n_divrst;
    send(8'hA5, 2'd0);
    wait_rx("lb", 100);
    chk("lb_rx_data", 32'(bus.rx_data), 32'hA5);
    repeat (3) @(negedge FCLK);
    chk("lb_rises", 32'(n_rise - r0), 32'd8);
    chk("lb_period", 32'(last_per), 32'd2);
    chk("lb_mosi_bits", {24'd0, mosi_hist[7:0]}, 32'hA5);
    chk("lb_rx_pulses", 32'(n_rvld - v0), 32'd1);
    chk("lb_div_rst_cyc", 32'(n_divrst - d0), 32'd1);
    // 1 + 8*2 + 2, plus the divider alignment cycle.
    chk("lb_cs_low", 32'(last_cs_low), 32'd20);

    // Slow divider, sel=3, MISO fixed high.
    loop_en = 1'b0; miso_fix = 1'b1;
    r0 = n_rise;
    send(8'h3C, 2'd3);
    wait_rx("slow", 400);
    chk("slow_rx_data", 32'(bus.rx_data), 32'hFF);
    repeat (3) @(negedge FCLK);
    chk("slow_rises", 32'(n_rise - r0), 32'd8);
    chk("slow_period", 32'(last_per), 32'd16);
    chk("slow_mosi_bits", {24'd0, mosi_hist[7:0]}, 32'h3C);
    chk("slow_cs_low", 32'(last_cs_low), 32'd132);

    // Back-to-back with tx_valid held.
    loop_en = 1'b1;
    v0 = n_rvld;
    @(negedge FCLK);
    bus.tx_valid = 1'b1; bus.tx_data = 8'h01; bus.div_sel = 2'd0;
    k = 0;
    do begin @(negedge FCLK); k++; end while (!bus.busy && k < 20);
    bus.tx_data = 8'h80;
    wait_rx("b2b_first", 100);
    chk("b2b_rx_first", 32'(bus.rx_data), 32'h01);
    k = 0;
    while (!bus.tx_ready && k < 20) begin @(negedge FCLK); k++; end
    @(negedge FCLK);
    bus.tx_valid = 1'b0;
    wait_rx("b2b_second", 100);
    chk("b2b_rx_second", 32'(bus.rx_data), 32'h80);
    repeat (3) @(negedge FCLK);
    chk("b2b_cs_gap", 32'(last_cs_high), 32'd5);
    chk("b2b_rx_pulses", 32'(n_rvld - v0), 32'd2);

    // Abort after the third SCLK rise.
    v0 = n_rvld; g0 = n_glitch;
    send(8'hFF, 2'd1);
    rises = 0; sp = 1'b0; k = 0;
    while (rises < 3 && k < 100) begin
      @(negedge FCLK);
      k++;
      if (spi_sclk && !sp) rises++;
      sp = spi_sclk;
    end
    chk("abort_saw_3_rises", 32'(rises), 32'd3);
    bus.abort = 1'b1;
    @(negedge FCLK);
    bus.abort = 1'b0;
    chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(spi_sclk), 32'd0);
    chk("abort_tx_ready", 32'(bus.tx_ready), 32'd0);
    gcyc = 1; k = 0;
    while (k < 20) begin
      @(negedge FCLK);
      k++;
      if (bus.tx_ready) break;
      gcyc++;
    end
    chk("abort_gap_cycles", 32'(gcyc), 32'd4);
    chk("abort_rx_kept", 32'(bus.rx_data), 32'h80);
    chk("abort_no_rx", 32'(n_rvld - v0), 32'd0);
    chk("abort_no_glitch", 32'(n_glitch - g0), 32'd0);
    send(8'h5A, 2'd0);
    wait_rx("post_abort", 100);
    chk("post_abort_rx", 32'(bus.rx_data), 32'h5A);

    // Reset mid-SHIFT.
    send(8'h33, 2'd2);
    repeat (10) @(negedge FCLK);
    chk("midrst_busy", 32'(bus.busy), 32'd1);
    RST_N = 1'b0;
    @(negedge FCLK);
    RST_N = 1'b1;
    chk_reset_outputs("midrst");
    v0 = n_rvld;
    repeat (150) @(negedge FCLK);
    chk("midrst_no_rx", 32'(n_rvld - v0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
